// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared definitions for the generic elastic pipeline stage.
//   - stage state encoding (EMPTY / BUSY / FULL)
//   - reset level constants
//   - default payload width
//   - per-stage payload field offsets so EX/MEM and MEM/WB pack/unpack alike
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    localparam int unsigned PIPE_PAYLOAD_W = 64;

    // EX/MEM payload layout
    localparam int unsigned EXMEM_ALU_LSB    = 0;
    localparam int unsigned EXMEM_ALU_W      = 32;
    localparam int unsigned EXMEM_WRADDR_LSB = EXMEM_ALU_LSB + EXMEM_ALU_W;
    localparam int unsigned EXMEM_WRADDR_W   = 5;
    localparam int unsigned EXMEM_WREN_LSB   = EXMEM_WRADDR_LSB + EXMEM_WRADDR_W;
    localparam int unsigned EXMEM_CSR_LSB    = EXMEM_WREN_LSB + 1;
    localparam int unsigned EXMEM_CSR_W      = 12;

    // MEM/WB payload layout
    localparam int unsigned MEMWB_WDATA_LSB  = 0;
    localparam int unsigned MEMWB_WDATA_W    = 32;
    localparam int unsigned MEMWB_WRADDR_LSB = MEMWB_WDATA_LSB + MEMWB_WDATA_W;
    localparam int unsigned MEMWB_WRADDR_W   = 5;
    localparam int unsigned MEMWB_WREN_LSB   = MEMWB_WRADDR_LSB + MEMWB_WRADDR_W;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready/payload handshake bundle.
//   valid : producer has a beat
//   ready : consumer can accept the beat
//   data  : PAYLOAD_W-bit opaque payload
// Modports: master = producer side, slave = consumer side.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = PIPE_PAYLOAD_W
) ();

    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk : clock
//   rst : synchronous active-high clear
//   inc : count this cycle
//   cnt : current count
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic pipeline stage with a 2-entry skid buffer.
// Upstream ready comes straight from a register (plus flush), latency is one
// cycle and throughput is one beat per cycle while downstream is ready.
//   clk             : clock, rising edge
//   rst             : synchronous reset, active-high
//   flush           : squash all held beats; nothing accepted this cycle
//   in_if  (slave)  : upstream valid/ready/data
//   out_if (master) : downstream valid/ready/data, driven from main register
//   occupancy       : beats held, 0..2
//   perf_stall_cnt  : cycles with out_valid & ~out_ready   (PIPE_STAGE_PERF_CNT_EN)
//   perf_bubble_cnt : cycles with ~out_valid out of reset  (PIPE_STAGE_PERF_CNT_EN)
// Optional feature macro: PIPE_STAGE_PERF_CNT_EN enables the saturating
// performance counters and their ports.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W = PIPE_PAYLOAD_W,
    parameter logic [PAYLOAD_W-1:0] RST_VAL   = '0,
    parameter int unsigned          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_reg_if.slave  in_if,
    pipe_stage_reg_if.master out_if,
`ifdef PIPE_STAGE_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_bubble_cnt,
`endif
    output logic [1:0]       occupancy
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W must be at least 1");
    end

    pipe_state_e          state;
    logic                 main_v;
    logic                 skid_v;
    logic [PAYLOAD_W-1:0] main_d;
    logic [PAYLOAD_W-1:0] skid_d;

    logic in_ready;
    logic in_fire;
    logic out_fire;

    assign in_ready     = ~skid_v & ~flush;
    assign in_if.ready  = in_ready;
    assign in_fire      = in_if.valid & in_ready;
    assign out_fire     = main_v & out_if.ready;

    assign out_if.valid = main_v;
    assign out_if.data  = main_d;
    assign occupancy    = {1'b0, main_v} + {1'b0, skid_v};

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state  <= ST_EMPTY;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RST_VAL;
            skid_d <= RST_VAL;
        end else if (flush) begin
            // Payload registers deliberately keep their contents.
            state  <= ST_EMPTY;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state  <= ST_BUSY;
                        main_v <= 1'b1;
                        main_d <= in_if.data;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d <= in_if.data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat in the skid slot.
                        state  <= ST_FULL;
                        skid_v <= 1'b1;
                        skid_d <= in_if.data;
                    end else if (out_fire) begin
                        state  <= ST_EMPTY;
                        main_v <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state  <= ST_BUSY;
                        skid_v <= 1'b0;
                        main_d <= skid_d;
                    end
                end
                default: begin
                    state  <= ST_EMPTY;
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst)
        !(skid_v && !main_v));

`ifdef PIPE_STAGE_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (main_v & ~out_if.ready),
        .cnt (perf_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~main_v),
        .cnt (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned  PW    = 16;
    localparam logic [PW-1:0] RSTV = 16'h5A5A;
    localparam int unsigned  CW    = 4;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CW-1:0] perf_stall_cnt;
    logic [CW-1:0] perf_bubble_cnt;
`endif

    pipe_stage_reg_if #(.PAYLOAD_W(PW)) in_if ();
    pipe_stage_reg_if #(.PAYLOAD_W(PW)) out_if ();

    pipe_stage_reg #(
        .PAYLOAD_W (PW),
        .RST_VAL   (RSTV),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_if           (in_if),
        .out_if          (out_if),
`ifdef PIPE_STAGE_PERF_CNT_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          flush;
        logic          iv;
        logic [PW-1:0] din;
        logic          ordy;
        logic          chk_ir;
        logic          exp_ir;
        logic          exp_ov;
        logic [PW-1:0] exp_od;
        logic [1:0]    exp_occ;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [PW-1:0] d, input logic ordy,
                                input logic cir, input logic eir, input logic eov,
                                input logic [PW-1:0] eod, input logic [1:0] eocc);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = ordy;
        v.chk_ir = cir; v.exp_ir = eir; v.exp_ov = eov; v.exp_od = eod; v.exp_occ = eocc;
        return v;
    endfunction

    localparam int NV = 24;
    vec_t vecs[NV];

    logic [PW-1:0] sb[$];

    initial begin
        // Inputs are applied after each rising edge; in_ready is checked just
        // before the next edge, registered outputs just after it.
        //             rst flush iv din       ordy cir eir eov eod       eocc
        vecs[0]  = mk(1,  0,   1, 16'h00AA, 0,   0,  0,  0,  RSTV,     2'd0);
        vecs[1]  = mk(1,  0,   1, 16'h00AA, 0,   1,  1,  0,  RSTV,     2'd0);
        vecs[2]  = mk(0,  0,   1, 16'h00AA, 1,   1,  1,  1,  16'h00AA, 2'd1);
        for (int k = 1; k <= 8; k++)
            vecs[2+k] = mk(0, 0, 1, PW'(k), 1, 1, 1, 1, PW'(k), 2'd1);
        vecs[11] = mk(0,  0,   0, 16'h0000, 1,   1,  1,  0,  16'h0008, 2'd0);
        vecs[12] = mk(0,  0,   1, 16'h0011, 0,   1,  1,  1,  16'h0011, 2'd1);
        vecs[13] = mk(0,  0,   1, 16'h0022, 0,   1,  1,  1,  16'h0011, 2'd2);
        vecs[14] = mk(0,  0,   1, 16'h0033, 0,   1,  0,  1,  16'h0011, 2'd2);
        vecs[15] = mk(0,  0,   1, 16'h0033, 1,   1,  0,  1,  16'h0022, 2'd1);
        vecs[16] = mk(0,  0,   1, 16'h0033, 1,   1,  1,  1,  16'h0033, 2'd1);
        vecs[17] = mk(0,  0,   0, 16'h0000, 0,   1,  1,  1,  16'h0033, 2'd1);
        vecs[18] = mk(0,  0,   1, 16'h0055, 0,   1,  1,  1,  16'h0033, 2'd2);
        vecs[19] = mk(0,  1,   1, 16'h0044, 0,   1,  0,  0,  16'h0033, 2'd0);
        vecs[20] = mk(0,  0,   1, 16'h0044, 0,   1,  1,  1,  16'h0044, 2'd1);
        vecs[21] = mk(0,  0,   0, 16'h0000, 1,   1,  1,  0,  16'h0044, 2'd0);
        vecs[22] = mk(1,  1,   1, 16'h0066, 0,   1,  0,  0,  RSTV,     2'd0);
        vecs[23] = mk(0,  0,   0, 16'h0000, 0,   1,  1,  0,  RSTV,     2'd0);

        for (int i = 0; i < NV; i++) begin
            rst          = vecs[i].rst;
            flush        = vecs[i].flush;
            in_if.valid  = vecs[i].iv;
            in_if.data   = vecs[i].din;
            out_if.ready = vecs[i].ordy;
            #4;
            if (vecs[i].chk_ir) chk($sformatf("v%0d in_ready", i), 64'(in_if.ready), 64'(vecs[i].exp_ir));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_if.valid), 64'(vecs[i].exp_ov));
            chk($sformatf("v%0d out_data", i),  64'(out_if.data),  64'(vecs[i].exp_od));
            chk($sformatf("v%0d occupancy", i), 64'(occupancy),    64'(vecs[i].exp_occ));
        end

        // Random traffic against an in-order scoreboard.
        rst = 1'b0; flush = 1'b0;
        for (int c = 0; c < 100; c++) begin
            in_if.valid  = 1'($urandom_range(0, 1));
            in_if.data   = PW'($urandom);
            out_if.ready = 1'($urandom_range(0, 1));
            #4;
            if (out_if.valid && out_if.ready) begin
                if (sb.size() == 0) chk("rand unexpected beat", 64'(out_if.data), 64'hFFFF_FFFF_FFFF_FFFF);
                else                chk("rand order", 64'(out_if.data), 64'(sb.pop_front()));
            end
            if (in_if.valid && in_if.ready) sb.push_back(in_if.data);
            @(posedge clk); #1;
            chk("rand occupancy", 64'(occupancy), 64'(sb.size()));
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        for (int c = 0; c < 8 && sb.size() != 0; c++) begin
            #4;
            if (out_if.valid) chk("drain order", 64'(out_if.data), 64'(sb.pop_front()));
            @(posedge clk); #1;
        end
        chk("drain empty", 64'(sb.size()), 64'd0);
        chk("drain out_valid", 64'(out_if.valid), 64'd0);

`ifdef PIPE_STAGE_PERF_CNT_EN
        rst = 1'b1; in_if.valid = 1'b0; out_if.ready = 1'b0;
        @(posedge clk); #1;
        chk("perf reset stall", 64'(perf_stall_cnt), 64'd0);
        chk("perf reset bubble", 64'(perf_bubble_cnt), 64'd0);
        rst = 1'b0;
        // two idle cycles, then a beat arrives (third empty cycle), then 5 stalls
        for (int c = 0; c < 3; c++) begin
            in_if.valid = (c == 2);
            in_if.data  = 16'h0077;
            @(posedge clk); #1;
        end
        in_if.valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        chk("perf stall 5", 64'(perf_stall_cnt), 64'd5);
        chk("perf bubble 3", 64'(perf_bubble_cnt), 64'd3);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        chk("perf stall saturate", 64'(perf_stall_cnt), 64'd15);
        chk("perf bubble hold", 64'(perf_bubble_cnt), 64'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("perf clear stall", 64'(perf_stall_cnt), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
